// File: rtl/afifo_wr_arb_if.sv
// afifo_wr_arb_if: requester and FIFO write-side bundle shared by the write-port arbiter
interface afifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
);
    localparam int GW = $clog2(NREQ);
    logic [NREQ-1:0]       i_req;
    logic [NREQ*DSIZE-1:0] i_data;
    logic [NREQ-1:0]       i_last;
    logic [NREQ-1:0]       o_ack;
    logic                  o_wr;
    logic [DSIZE-1:0]      o_wdata;
    logic                  i_wfull;
    logic                  o_busy;
    logic [GW-1:0]         o_gnt_id;
    modport master (
        output i_req, i_data, i_last, i_wfull,
        input  o_ack, o_wr, o_wdata, o_busy, o_gnt_id
    );
    modport slave (
        input  i_req, i_data, i_last, i_wfull,
        output o_ack, o_wr, o_wdata, o_busy, o_gnt_id
    );
endinterface

// File: rtl/afifo_wr_arb.sv
// afifo_wr_arb: round-robin burst arbiter sharing the afifo write port among NREQ requesters
module afifo_wr_arb #(
    parameter int NREQ      = 4,
    parameter int DSIZE     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    afifo_wr_arb_if.slave  bus
);
    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, BURST} state_t;
    state_t          state, state_nx;
    logic [GW-1:0]   gnt, gnt_nx, rr_ptr, rr_nx, sel;
    logic [BW-1:0]   beat_cnt, beat_nx;
    logic            found, busy, xfer, rel, last_beat;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nx;
            gnt      <= gnt_nx;
            rr_ptr   <= rr_nx;
            beat_cnt <= beat_nx;
        end
    end
    // reset gates the outputs combinationally so a mid-burst reset never writes
    assign busy      = i_rst_n & (state == BURST);
    assign xfer      = busy & bus.i_req[gnt] & ~bus.i_wfull;
    assign last_beat = bus.i_last[gnt] | (beat_cnt == BW'(MAX_BURST - 1));
    assign rel       = busy & (~bus.i_req[gnt] | (xfer & last_beat));
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        rr_nx    = rr_ptr;
        beat_nx  = beat_cnt;
        sel      = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (!found && bus.i_req[(int'(rr_ptr) + i) % NREQ]) begin
                found = 1'b1;
                sel   = GW'((int'(rr_ptr) + i) % NREQ);
            end
        if (state == IDLE && found) begin
            state_nx = BURST;
            gnt_nx   = sel;
            beat_nx  = '0;
        end
        if (xfer)
            beat_nx = beat_cnt + 1'b1;
        if (rel) begin
            state_nx = IDLE;
            rr_nx    = (gnt == GW'(NREQ - 1)) ? '0 : gnt + 1'b1;
        end
    end
    assign bus.o_wr     = xfer;
    assign bus.o_ack    = {{(NREQ-1){1'b0}}, xfer} << gnt;
    assign bus.o_wdata  = busy ? bus.i_data[int'(gnt)*DSIZE +: DSIZE] : '0;
    assign bus.o_busy   = busy;
    assign bus.o_gnt_id = busy ? gnt : '0;
endmodule

// File: tb/tb_afifo_wr_arb.sv
// tb_afifo_wr_arb: randomized requesters checked against a transaction-level arbiter model via a scoreboard
module tb_afifo_wr_arb;
    localparam int NREQ      = 4;
    localparam int DSIZE     = 8;
    localparam int MAX_BURST = 4;

    typedef struct {
        int               id;
        logic [DSIZE-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    afifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus();
    afifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAX_BURST(MAX_BURST)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    wr_t              sb[$];
    int               checks = 0;
    int               errors = 0;
    logic [DSIZE-1:0] cur_data [NREQ];
    logic             cur_last [NREQ];
    logic             acked    [NREQ];

    // model: who owns the port, words written in this grant, who has priority next
    bit               m_busy;
    int               m_owner, m_beats, m_next;
    logic             exp_wr, exp_busy;
    int               exp_gnt;
    logic [DSIZE-1:0] exp_wdata;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        exp_busy  = rst_n && m_busy;
        exp_gnt   = exp_busy ? m_owner : 0;
        exp_wdata = exp_busy ? cur_data[m_owner] : '0;
        exp_wr    = 1'b0;
        for (int n = 0; n < NREQ; n++) acked[n] = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_next = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (m_next + k) % NREQ;
                if (bus.i_req[c]) begin
                    m_busy  = 1'b1;
                    m_owner = c;
                    m_beats = 0;
                    break;
                end
            end
        end else if (!bus.i_req[m_owner]) begin
            m_busy = 1'b0;
            m_next = (m_owner + 1) % NREQ;
        end else if (!bus.i_wfull) begin
            exp_wr = 1'b1;
            acked[m_owner] = 1'b1;
            sb.push_back('{m_owner, cur_data[m_owner]});
            m_beats++;
            if (cur_last[m_owner] || m_beats == MAX_BURST) begin
                m_busy = 1'b0;
                m_next = (m_owner + 1) % NREQ;
            end
        end
    endtask

    task automatic run_phase(int ncyc, logic [NREQ-1:0] mask, int req_pct, int last_pct,
                             int full_pct, int rst_pct);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            for (int n = 0; n < NREQ; n++)
                if (acked[n]) begin
                    cur_data[n]++;
                    cur_last[n] = ($urandom_range(99) < last_pct);
                end
            rst_n = ($urandom_range(99) >= rst_pct);
            for (int n = 0; n < NREQ; n++) begin
                bus.i_req[n] = mask[n] && ($urandom_range(99) < req_pct);
                bus.i_data[n*DSIZE +: DSIZE] = cur_data[n];
                bus.i_last[n] = cur_last[n];
            end
            bus.i_wfull = ($urandom_range(99) < full_pct);
            model_step();
        end
    endtask

    task automatic new_phase(int last_pct);
        run_phase(2, '0, 0, 0, 0, 0);
        for (int n = 0; n < NREQ; n++) cur_last[n] = ($urandom_range(99) < last_pct);
    endtask

    always @(negedge clk) begin
        chk("wr", bus.o_wr, exp_wr);
        chk("busy", bus.o_busy, exp_busy);
        chk("gnt_id", bus.o_gnt_id, exp_gnt);
        chk("wdata", bus.o_wdata, exp_wdata);
        chk("ack_vs_wr", |bus.o_ack, bus.o_wr);
        chk("wr_when_full", bus.o_wr & bus.i_wfull, 0);
        if (bus.o_wr) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_ack", bus.o_ack, 32'(1) << e.id);
                chk("sb_data", bus.o_wdata, e.data);
            end
        end
    end

    initial begin
        bus.i_req   = '0;
        bus.i_data  = '0;
        bus.i_last  = '0;
        bus.i_wfull = 1'b0;
        for (int n = 0; n < NREQ; n++) begin
            cur_data[n] = DSIZE'(n * 8'h40);
            cur_last[n] = 1'b1;
            acked[n]    = 1'b0;
        end
        m_busy = 1'b0; m_owner = 0; m_beats = 0; m_next = 0;
        exp_wr = 1'b0; exp_busy = 1'b0; exp_gnt = 0; exp_wdata = '0;
        run_phase(3, 4'hF, 100, 100, 0, 100);
        run_phase(20, 4'hF, 100, 100, 0, 0);
        new_phase(0);
        cur_data[2] = 8'h10;
        run_phase(14, 4'h4, 100, 0, 0, 0);
        new_phase(0);
        run_phase(40, 4'h2, 100, 0, 40, 0);
        new_phase(30);
        run_phase(80, 4'h9, 70, 30, 10, 0);
        new_phase(25);
        run_phase(3000, 4'hF, 80, 25, 20, 2);
        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
